mimo_fifo_n: RTL

- Parametrised successor to the 8-lane MIMO FIFO.
- Accepts one beat of NUM_PORTS lanes. Each lane carries data and a destination branch index; words are routed into per-branch output FIFOs.
- New relative to the previous generation:
  - NUM_PORTS, WIDTH and DEPTH are all parametrised.
  - Per-lane enable mask.
  - Deterministic serialisation when several lanes target the same branch.
  - Per-branch downstream backpressure.
- Sits between the channeliser lane fan-out and the per-branch consumers.

---
 rtl/mimo_fifo_pkg.sv | 32 +++
 rtl/mimo_fifo_branch.sv | 78 +++++++
 rtl/mimo_fifo_n.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mimo_fifo_pkg.sv
// Shared helpers for the parametrised MIMO FIFO: derived widths and the
// lowest-index lane selection used when several lanes target one branch.
package mimo_fifo_pkg;

    // Widest lane count the grant encoder handles.
    localparam int MAX_PORTS = 64;

    // Default branch depth and the pointer width derived from it.
    localparam int DEFAULT_DEPTH = 128;
    localparam int DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH);

    // Width of a branch index for n branches.
    function automatic int calc_sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Pointer width of a circular buffer holding depth words.
    function automatic int calc_ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Lowest set bit of req, or -1 when no bit is set.
    function automatic int lowest_index(input logic [MAX_PORTS-1:0] req);
        int idx;
        idx = -1;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (req[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mimo_fifo_branch.sv
// One output branch: single-push, single-pop first-word-fall-through FIFO.
// The head word is kept in a register so o_data holds its last value while
// the FIFO is empty and reads zero after reset.
module mimo_fifo_branch
    import mimo_fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 128
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = calc_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] head_q;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count == FULL_CNT);
    assign o_empty = (count == '0);
    // A pop on an empty FIFO is ignored; a push while full only lands if the
    // same edge frees a slot, so nothing is ever overwritten.
    assign pop_ok  = i_pop & ~o_empty;
    assign push_ok = i_push & (~o_full | pop_ok);
    assign o_data  = head_q;

    // Next read pointer and occupancy for this edge.
    always_comb begin
        rd_ptr_next = pop_ok ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        count_next  = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge i_clock) begin
        if (push_ok) mem[wr_ptr] <= i_push_data;
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            // The new head is either already stored or is the word being
            // written right now into the slot the read pointer lands on.
            if (count_next != '0) begin
                head_q <= (push_ok && (wr_ptr == rd_ptr_next)) ? i_push_data
                                                                : mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/mimo_fifo_n.sv
// Parametrised MIMO FIFO: one beat of NUM_PORTS lanes is staged, and each
// lane's word is routed to the FIFO of its destination branch. Lanes that
// collide on a branch drain one per cycle in ascending lane order.
//
// Handshakes: the input beat transfers on a rising edge where
// i_valid & o_ready; branch b transfers its head word on a rising edge where
// o_valid[b] & i_ready[b]. o_ready never depends on i_valid, and o_valid[b]
// never depends on i_ready[b].
module mimo_fifo_n
    import mimo_fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 128,
    parameter int NUM_PORTS = 8,
    localparam int SEL_W    = calc_sel_w(NUM_PORTS)
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic [NUM_PORTS*WIDTH-1:0] i_data,
    input  logic [NUM_PORTS*SEL_W-1:0] i_to_branch,
    input  logic [NUM_PORTS-1:0]       i_lane_en,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [NUM_PORTS*WIDTH-1:0] o_data,
    output logic [NUM_PORTS-1:0]       o_valid,
    input  logic [NUM_PORTS-1:0]       i_ready,
    output logic                       o_err_branch
);

    logic [WIDTH-1:0]     stage_data   [NUM_PORTS];
    logic [SEL_W-1:0]     stage_branch [NUM_PORTS];
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] lane_grant;
    logic [NUM_PORTS-1:0] lane_oor;
    logic                 ready_en;
    logic                 err_q;
    logic                 accept;

    logic [NUM_PORTS-1:0] br_push;
    logic [WIDTH-1:0]     br_push_data [NUM_PORTS];
    logic [WIDTH-1:0]     br_data      [NUM_PORTS];
    logic [NUM_PORTS-1:0] br_full;
    logic [NUM_PORTS-1:0] br_empty;
    logic [NUM_PORTS-1:0] br_valid;
    logic [NUM_PORTS-1:0] br_pop;

    assign br_valid     = ~br_empty;
    assign br_pop       = br_valid & i_ready;
    assign o_valid      = br_valid;
    assign o_err_branch = err_q;
    // Ready once every still-pending lane is being granted this cycle, so a
    // new beat can land on the edge the previous one finishes draining.
    assign o_ready      = ready_en & ((pending & ~lane_grant) == '0);
    assign accept       = i_valid & o_ready;

    // Flag lanes whose destination index names a branch that does not exist.
    always_comb begin
        lane_oor = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            lane_oor[k] = int'(i_to_branch[k*SEL_W +: SEL_W]) >= NUM_PORTS;
        end
    end

    // Per-branch grant: lowest pending lane aimed at the branch, issued only
    // when the branch FIFO has room or is being popped on the same edge.
    always_comb begin
        logic [NUM_PORTS-1:0] req;
        int                   sel_idx;
        lane_grant = '0;
        br_push    = '0;
        req        = '0;
        sel_idx    = -1;
        for (int b = 0; b < NUM_PORTS; b++) begin
            br_push_data[b] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                req[k] = pending[k] && (int'(stage_branch[k]) == b);
            end
            sel_idx = lowest_index(MAX_PORTS'(req));
            if ((sel_idx >= 0) && (!br_full[b] || br_pop[b])) begin
                br_push[b] = 1'b1;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (k == sel_idx) begin
                        lane_grant[k]   = 1'b1;
                        br_push_data[b] = stage_data[k];
                    end
                end
            end
        end
    end

    // Staging register for lane words and destinations of the accepted beat.
    always_ff @(posedge i_clock) begin
        if (accept) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                stage_data[k]   <= i_data[k*WIDTH +: WIDTH];
                stage_branch[k] <= i_to_branch[k*SEL_W +: SEL_W];
            end
        end
    end

    // Pending mask, post-reset ready enable and the sticky range error.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending  <= '0;
            ready_en <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                pending <= i_lane_en & ~lane_oor;
                if ((i_lane_en & lane_oor) != '0) err_q <= 1'b1;
            end else begin
                pending <= pending & ~lane_grant;
            end
        end
    end

    for (genvar b = 0; b < NUM_PORTS; b++) begin : g_branch
        mimo_fifo_branch #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_branch (
            .i_clock     (i_clock),
            .i_reset_n   (i_reset_n),
            .i_push      (br_push[b]),
            .i_push_data (br_push_data[b]),
            .i_pop       (br_pop[b]),
            .o_data      (br_data[b]),
            .o_full      (br_full[b]),
            .o_empty     (br_empty[b])
        );
        assign o_data[b*WIDTH +: WIDTH] = br_data[b];
    end

endmodule
